// File: rtl/ps2_avalon_pkg.sv
// ps2_avalon_pkg
//   Shared definitions for the queued PS/2 Avalon-MM slave:
//   register word offsets, CONTROL bit positions, the command FSM state
//   encoding and a helper that sizes FIFO occupancy counters.
package ps2_avalon_pkg;

  // Word offsets on the 2-bit Avalon address
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_COMMAND = 2'd2;
  localparam logic [1:0] ADDR_THRESH  = 2'd3;

  // CONTROL register bit positions
  localparam int CTL_RE    = 0;   // receive interrupt enable (rw)
  localparam int CTL_RI    = 8;   // interrupt line state (ro)
  localparam int CTL_CE    = 10;  // command error, sticky W1C
  localparam int CTL_OVF   = 11;  // rx overflow, sticky W1C
  localparam int CTL_DROP  = 12;  // command FIFO overflow, sticky W1C
  localparam int CTL_CFULL = 13;  // command FIFO full (ro)
  localparam int CTL_BUSY  = 14;  // command FSM not idle (ro)

  // Command FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FAIL = 2'd2,
    ST_GAP  = 2'd3
  } cmd_state_e;

  // Occupancy counter width for a FIFO of 'depth' entries (holds 0..depth)
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo
//   Show-ahead synchronous FIFO with an occupancy count and a synchronous clear.
//   Push while full is ignored unless a pop happens in the same cycle; pop while
//   empty is ignored (a simultaneous push into an empty FIFO is push-only).
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   i_clr    in   synchronous flush (pointers and count to 0)
//   i_push   in   write i_din
//   i_pop    in   discard the head entry
//   i_din    in   WIDTH  write data
//   o_dout   out  WIDTH  head entry (valid when !o_empty)
//   o_count  out  entries held, 0..DEPTH
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot, so a full FIFO still accepts a same-cycle push
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_avalon_mm_queued.sv
// ps2_avalon_mm_queued
//   Avalon-MM slave between a Nios host and one external PS/2 serial engine.
//   Receive bytes land in an RX FIFO read through DATA; host writes to COMMAND
//   queue bytes that a small FSM hands to the engine one at a time, with a
//   guaranteed one-cycle low gap on cmd_send between bytes. The bus never stalls.
// Configuration
//   PS2_CMD_RETRY_EN  defined: a timed-out byte is resent up to CMD_RETRIES more
//                     times before CE is raised. Undefined: first timeout raises CE.
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   address[1:0]                0 DATA, 1 CONTROL, 2 COMMAND, 3 THRESH
//   chipselect, read, write     Avalon strobes
//   byteenable[3:0]             byte lanes
//   writedata[31:0]             write data
//   readdata[31:0]              registered read data, latency 1
//   irq                         registered level interrupt
//   cmd_data[7:0], cmd_send     byte and level request to engine
//   cmd_sent, cmd_timeout       one-cycle completion pulses from engine
//   rx_data[7:0], rx_valid      received byte and its strobe
module ps2_avalon_mm_queued
  import ps2_avalon_pkg::*;
#(
  parameter int RX_DEPTH    = 256,
  parameter int CMD_DEPTH   = 4,
  parameter int CMD_RETRIES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [7:0]  cmd_data,
  output logic        cmd_send,
  input  logic        cmd_sent,
  input  logic        cmd_timeout,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int RX_COUNT_W  = count_w(RX_DEPTH);
  localparam int CMD_COUNT_W = count_w(CMD_DEPTH);

  // Bus decode
  logic w_rd, w_wr;
  logic w_rx_pop, w_cmd_push, w_ctl_wr, w_thr_wr;

  assign w_rd       = chipselect & read;
  assign w_wr       = chipselect & write;
  assign w_rx_pop   = w_rd & (address == ADDR_DATA) & byteenable[0];
  assign w_cmd_push = w_wr & (address == ADDR_COMMAND) & byteenable[0];
  assign w_ctl_wr   = w_wr & (address == ADDR_CONTROL);
  assign w_thr_wr   = w_wr & (address == ADDR_THRESH);

  // RX FIFO
  logic [7:0]            w_rx_head;
  logic [RX_COUNT_W-1:0] w_rx_count;
  logic                  w_rx_full, w_rx_empty;

  ps2_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (1'b0),
    .i_push  (rx_valid),
    .i_pop   (w_rx_pop),
    .i_din   (rx_data),
    .o_dout  (w_rx_head),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Command FIFO
  logic [7:0]             w_cmd_head;
  logic [CMD_COUNT_W-1:0] w_cmd_count;
  logic                   w_cmd_full, w_cmd_empty;
  logic                   w_cmd_pop, w_cmd_flush;

  ps2_sync_fifo #(.WIDTH(8), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cmd_flush),
    .i_push  (w_cmd_push),
    .i_pop   (w_cmd_pop),
    .i_din   (writedata[7:0]),
    .o_dout  (w_cmd_head),
    .o_count (w_cmd_count),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty)
  );

  // Command FSM
  cmd_state_e r_state, w_state_next;
  logic [7:0] r_cmd_data;
  logic       w_retry_ok;     // FAIL may resend the current byte
  logic       w_retry;        // FAIL is resending this cycle
  logic       w_fail_final;   // FAIL gives up: raise CE and flush
  logic       w_gap_to_send;  // GAP returns to SEND for a retry
  logic       w_cmd_send;

`ifdef PS2_CMD_RETRY_EN
  localparam int TRIES_W = (CMD_RETRIES < 1) ? 1 : $clog2(CMD_RETRIES + 1);
  logic [TRIES_W-1:0] r_tries;
  logic               r_retry;

  assign w_retry_ok    = (r_tries < TRIES_W'(CMD_RETRIES));
  assign w_gap_to_send = r_retry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tries <= '0;
      r_retry <= 1'b0;
    end else begin
      if (w_cmd_pop)    r_tries <= '0;
      else if (w_retry) r_tries <= r_tries + 1'b1;
      // Remember across GAP whether the byte is being resent
      if (r_state == ST_FAIL)      r_retry <= w_retry_ok;
      else if (r_state == ST_SEND) r_retry <= 1'b0;
    end
  end
`else
  logic w_unused_retries;
  assign w_unused_retries = (CMD_RETRIES != 0);
  assign w_retry_ok       = 1'b0;
  assign w_gap_to_send    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (!w_cmd_empty) w_state_next = ST_SEND;
      // A simultaneous sent+timeout counts as delivered
      ST_SEND: begin
        if (cmd_sent)         w_state_next = ST_GAP;
        else if (cmd_timeout) w_state_next = ST_FAIL;
      end
      ST_FAIL: w_state_next = ST_GAP;
      ST_GAP:  w_state_next = w_gap_to_send ? ST_SEND : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_send   = (r_state == ST_SEND);
    w_cmd_pop    = (r_state == ST_IDLE) & ~w_cmd_empty;
    w_retry      = (r_state == ST_FAIL) & w_retry_ok;
    w_fail_final = (r_state == ST_FAIL) & ~w_retry_ok;
  end

  assign w_cmd_flush = w_fail_final;

  always_ff @(posedge clk) begin
    if (reset)          r_cmd_data <= 8'h00;
    else if (w_cmd_pop) r_cmd_data <= w_cmd_head;
  end

  assign cmd_send = w_cmd_send;
  assign cmd_data = r_cmd_data;

  // CONTROL / THRESH registers and status flags
  logic        r_re, r_ce, r_ovf, r_drop, r_irq;
  logic [15:0] r_thresh;
  logic        w_ce_set, w_ovf_set, w_drop_set;
  logic        w_w1c;
  logic [15:0] w_rx_count16, w_thresh_eff;

  assign w_w1c      = w_ctl_wr & byteenable[1];
  assign w_ce_set   = w_fail_final;
  // With a same-cycle pop the full FIFO has room, so nothing is lost
  assign w_ovf_set  = rx_valid & w_rx_full & ~w_rx_pop;
  assign w_drop_set = w_cmd_push & w_cmd_full & ~w_cmd_pop;

  assign w_rx_count16 = 16'(w_rx_count);
  assign w_thresh_eff = (r_thresh == 16'd0) ? 16'd1 : r_thresh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_re     <= 1'b0;
      r_ce     <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
      r_irq    <= 1'b0;
      r_thresh <= 16'd1;
    end else begin
      if (w_ctl_wr && byteenable[0]) r_re <= writedata[CTL_RE];
      // Hardware set overrides a same-cycle W1C clear
      r_ce   <= w_ce_set   | (r_ce   & ~(w_w1c & writedata[CTL_CE]));
      r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_w1c & writedata[CTL_OVF]));
      r_drop <= w_drop_set | (r_drop & ~(w_w1c & writedata[CTL_DROP]));
      if (w_thr_wr && byteenable[0]) r_thresh[7:0]  <= writedata[7:0];
      if (w_thr_wr && byteenable[1]) r_thresh[15:8] <= writedata[15:8];
      r_irq <= r_re & ((w_rx_count16 >= w_thresh_eff) | r_ce);
    end
  end

  assign irq = r_irq;

  // Read mux; DATA reports the pre-pop head, masked to 0 when empty
  logic [31:0] w_rdata;
  logic [31:0] r_readdata;

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: begin
        w_rdata[31:16] = w_rx_count16;
        w_rdata[15]    = ~w_rx_empty;
        w_rdata[7:0]   = w_rx_empty ? 8'h00 : w_rx_head;
      end
      ADDR_CONTROL: begin
        w_rdata[CTL_RE]    = r_re;
        w_rdata[CTL_RI]    = r_irq;
        w_rdata[CTL_CE]    = r_ce;
        w_rdata[CTL_OVF]   = r_ovf;
        w_rdata[CTL_DROP]  = r_drop;
        w_rdata[CTL_CFULL] = w_cmd_full;
        w_rdata[CTL_BUSY]  = (r_state != ST_IDLE);
      end
      // 8-bit field: a completely full 256-entry queue reads 0 here, CFULL disambiguates
      ADDR_COMMAND: w_rdata[15:8] = 8'(w_cmd_count);
      default:      w_rdata[15:0] = r_thresh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rdata;
    else           r_readdata <= '0;
  end

  assign readdata = r_readdata;

  logic w_unused_bits;
  assign w_unused_bits = ^{byteenable[3:2], writedata[31:16]};

endmodule

// File: tb/tb_ps2_avalon_mm_queued.sv
module tb_ps2_avalon_mm_queued;
  import ps2_avalon_pkg::*;

  localparam int RX_DEPTH    = 256;
  localparam int CMD_DEPTH   = 4;
  localparam int CMD_RETRIES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  cmd_data;
  logic        cmd_send;
  logic        cmd_sent = 1'b0;
  logic        cmd_timeout = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  ps2_avalon_mm_queued #(
    .RX_DEPTH(RX_DEPTH), .CMD_DEPTH(CMD_DEPTH), .CMD_RETRIES(CMD_RETRIES)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq), .cmd_data(cmd_data), .cmd_send(cmd_send),
    .cmd_sent(cmd_sent), .cmd_timeout(cmd_timeout), .rx_data(rx_data),
    .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Rising edges of cmd_send = number of SEND phases seen by the engine
  int   sends = 0;
  logic prev_send = 1'b0;
  always @(negedge clk) begin
    if (cmd_send && !prev_send) sends++;
    prev_send = cmd_send;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; byteenable = be; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; byteenable = '0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [3:0] be, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a; byteenable = be;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0; byteenable = '0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          wait_cnt;
    int          exp_sends;

    // ---- 1: reset state and basic receive ----
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_cmd_send", {31'b0, cmd_send}, 32'h0);
    check("rst_cmd_data", {24'b0, cmd_data}, 32'h0);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("rst_control", rd, 32'h0);
    bus_read(ADDR_THRESH,  4'hF, rd); check("rst_thresh", rd, 32'h1);

    rx_push(8'h1C); rx_push(8'hF0); rx_push(8'h1C);
    bus_read(ADDR_DATA, 4'h1, rd); check("data_pop0", rd, 32'h0003_801C);
    bus_read(ADDR_DATA, 4'h1, rd); check("data_pop1", rd, 32'h0002_80F0);
    bus_read(ADDR_DATA, 4'h1, rd); check("data_pop2", rd, 32'h0001_801C);
    bus_read(ADDR_DATA, 4'h1, rd); check("data_empty", rd, 32'h0);

    // ---- 2: RX overflow, byte values i+1 so the lost one is 0x01 ----
    for (int i = 0; i <= RX_DEPTH; i++) rx_push(8'(i + 1));
    bus_read(ADDR_CONTROL, 4'hF, rd); check("ovf_set", rd, 32'h0000_0800);
    bus_read(ADDR_DATA, 4'h0, rd);    check("ovf_full_peek", rd, 32'h0100_8001);
    for (int i = 0; i < RX_DEPTH - 1; i++) bus_read(ADDR_DATA, 4'h1, rd);
    bus_read(ADDR_DATA, 4'h1, rd);    check("ovf_last_kept", rd, 32'h0001_8000);
    bus_read(ADDR_DATA, 4'h1, rd);    check("ovf_drained", rd, 32'h0);
    bus_write(ADDR_CONTROL, 4'h2, 32'h0000_0800);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("ovf_w1c", rd, 32'h0);

    // ---- 3: threshold interrupt ----
    bus_write(ADDR_CONTROL, 4'h1, 32'h1);
    bus_write(ADDR_THRESH, 4'h3, 32'h4);
    bus_read(ADDR_THRESH, 4'hF, rd); check("thresh_rd", rd, 32'h4);
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    repeat (2) @(negedge clk);
    check("irq_below_thr", {31'b0, irq}, 32'h0);
    rx_push(8'h44);
    check("irq_not_yet", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_at_thr", {31'b0, irq}, 32'h1);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("ctl_ri", rd, 32'h0000_0101);
    bus_read(ADDR_DATA, 4'h1, rd);    check("irq_pop_data", rd, 32'h0004_8011);
    check("irq_pop_same", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_dropped", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) bus_read(ADDR_DATA, 4'h1, rd);

    // ---- 4: two queued commands ----
    bus_write(ADDR_COMMAND, 4'h1, 32'hFF);
    bus_write(ADDR_COMMAND, 4'h1, 32'hF4);
    check("cmd1_send", {31'b0, cmd_send}, 32'h1);
    check("cmd1_data", {24'b0, cmd_data}, 32'hFF);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("ctl_busy", rd, 32'h0000_4001);
    bus_read(ADDR_COMMAND, 4'hF, rd); check("cmd_count1", rd, 32'h0000_0100);
    repeat (3) @(negedge clk);
    check("cmd1_hold", {23'b0, cmd_send, cmd_data}, 32'h1FF);
    @(negedge clk); cmd_sent = 1'b1;
    @(negedge clk); cmd_sent = 1'b0;
    check("cmd_gap_low", {31'b0, cmd_send}, 32'h0);
    wait_cnt = 0;
    while (!cmd_send && wait_cnt < 8) begin @(negedge clk); wait_cnt++; end
    check("cmd2_started", {31'b0, cmd_send}, 32'h1);
    check("cmd2_data", {24'b0, cmd_data}, 32'hF4);
    @(negedge clk); cmd_sent = 1'b1;
    @(negedge clk); cmd_sent = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("cmd_idle", rd, 32'h0000_0001);

    // ---- 5: timeouts, retry and CE ----
    bus_write(ADDR_COMMAND, 4'h1, 32'hAA);
    sends = 0;
    bus_write(ADDR_COMMAND, 4'h1, 32'hBB);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cmd_timeout = cmd_send;
    end
    cmd_timeout = 1'b0;
    repeat (2) @(negedge clk);
`ifdef PS2_CMD_RETRY_EN
    exp_sends = CMD_RETRIES + 1;
`else
    exp_sends = 1;
`endif
    check("send_phases", sends, exp_sends);
    check("ce_cmd_send", {31'b0, cmd_send}, 32'h0);
    check("ce_cmd_data", {24'b0, cmd_data}, 32'hAA);
    check("ce_irq", {31'b0, irq}, 32'h1);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("ce_control", rd, 32'h0000_0501);
    bus_read(ADDR_COMMAND, 4'hF, rd); check("ce_flushed", rd, 32'h0);
    bus_write(ADDR_CONTROL, 4'h2, 32'h0000_0400);
    repeat (2) @(negedge clk);
    check("ce_clr_irq", {31'b0, irq}, 32'h0);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("ce_w1c", rd, 32'h0000_0001);

    // ---- command FIFO overflow: one byte in flight + 4 queued + 1 dropped ----
    for (int i = 1; i <= 6; i++) bus_write(ADDR_COMMAND, 4'h1, 32'(i));
    bus_read(ADDR_CONTROL, 4'hF, rd); check("drop_control", rd, 32'h0000_7001);
    bus_read(ADDR_COMMAND, 4'hF, rd); check("drop_count", rd, 32'h0000_0400);
    check("drop_inflight", {23'b0, cmd_send, cmd_data}, 32'h101);

    // ---- 6: reset during SEND ----
    rx_push(8'h55);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst2_cmd_send", {31'b0, cmd_send}, 32'h0);
    check("rst2_cmd_data", {24'b0, cmd_data}, 32'h0);
    check("rst2_irq", {31'b0, irq}, 32'h0);
    bus_read(ADDR_CONTROL, 4'hF, rd); check("rst2_control", rd, 32'h0);
    bus_read(ADDR_THRESH,  4'hF, rd); check("rst2_thresh", rd, 32'h1);
    bus_read(ADDR_COMMAND, 4'hF, rd); check("rst2_cmd_count", rd, 32'h0);
    bus_read(ADDR_DATA,    4'h1, rd); check("rst2_rx_empty", rd, 32'h0);
    repeat (3) @(negedge clk);
    check("rst2_no_send", {31'b0, cmd_send}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
